// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : Zero-wait data memory with byte-strobed RAM, LED/timer peripheral
//            window and a registered bus-error pulse for illegal stores.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int          RAM_AW      = 10,
    parameter logic [19:0] PERIPH_BASE = 20'hBFAF0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [15:0] led,
    output logic        timer_irq,
    output logic        bus_err
);

    localparam logic [5:0] c_OFF_LED    = 6'h00;
    localparam logic [5:0] c_OFF_COUNT  = 6'h01;
    localparam logic [5:0] c_OFF_CMP    = 6'h02;
    localparam logic [5:0] c_OFF_CTRL   = 6'h03;
    localparam logic [5:0] c_OFF_STATUS = 6'h04;

    logic [31:0]       r_ram [0:(2**RAM_AW)-1];
    logic [15:0]       r_led;
    logic [31:0]       r_count;
    logic [31:0]       r_cmp;
    logic              r_en;
    logic              r_autoreload;
    logic              r_ie;
    logic              r_match;
    logic              r_bus_err;

    logic              w_is_ram;
    logic              w_is_per;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [5:0]        w_off;
    logic              w_per_wr;
    logic              w_bad_wr;
    logic              w_hit;
    logic              w_unused;

    assign w_is_ram  = (addr[31:16] == 16'h0000);
    assign w_is_per  = (addr[31:12] == PERIPH_BASE);
    assign w_ram_idx = addr[RAM_AW+1:2];
    assign w_off     = addr[7:2];
    assign w_per_wr  = w_is_per && (memwrite == 4'hF);
    assign w_bad_wr  = (memwrite != 4'h0) &&
                       ((w_is_per && (memwrite != 4'hF)) || (!w_is_per && !w_is_ram));
    assign w_hit     = r_en && (r_count == r_cmp);
    assign w_unused  = &{1'b0, addr[15:2], addr[11:8], addr[1:0]};

    // RAM is deliberately not reset; stores are suppressed while rst is low.
    always_ff @(posedge clk) begin
        if (rst && w_is_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (memwrite[i]) begin
                    r_ram[w_ram_idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_led        <= 16'h0000;
            r_count      <= 32'h0000_0000;
            r_cmp        <= 32'hFFFF_FFFF;
            r_en         <= 1'b0;
            r_autoreload <= 1'b0;
            r_ie         <= 1'b0;
            r_match      <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_bus_err <= w_bad_wr;

            // CPU store to COUNT overrides the timer's own increment/reload.
            if (w_per_wr && (w_off == c_OFF_COUNT)) begin
                r_count <= writedata;
            end else if (r_en) begin
                r_count <= (w_hit && r_autoreload) ? 32'h0000_0000 : r_count + 32'd1;
            end

            // A new match wins over a simultaneous write-1-to-clear.
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_per_wr && (w_off == c_OFF_STATUS) && writedata[0]) begin
                r_match <= 1'b0;
            end

            if (w_per_wr && (w_off == c_OFF_LED)) begin
                r_led <= writedata[15:0];
            end
            if (w_per_wr && (w_off == c_OFF_CMP)) begin
                r_cmp <= writedata;
            end
            if (w_per_wr && (w_off == c_OFF_CTRL)) begin
                r_en         <= writedata[0];
                r_autoreload <= writedata[1];
                r_ie         <= writedata[2];
            end
        end
    end

    always_comb begin
        readdata = 32'h0000_0000;
        if (w_is_ram) begin
            readdata = r_ram[w_ram_idx];
        end else if (w_is_per) begin
            case (w_off)
                c_OFF_LED:    readdata = {16'h0000, r_led};
                c_OFF_COUNT:  readdata = r_count;
                c_OFF_CMP:    readdata = r_cmp;
                c_OFF_CTRL:   readdata = {29'd0, r_ie, r_autoreload, r_en};
                c_OFF_STATUS: readdata = {31'd0, r_match};
                default:      readdata = 32'h0000_0000;
            endcase
        end
    end

    assign led       = r_led;
    assign timer_irq = r_match & r_ie;
    assign bus_err   = r_bus_err;

endmodule
`default_nettype wire
